// File: rtl/io_map_pkg.sv
// io_map_pkg: shared IO address map for the CPU's memory-mapped IO blocks.
//  - SEL_* : addr[7:2] values of the input-port and output-port registers
//  - OFF_* : word offsets of the output-block registers from its base select
//  - CTRL / STATUS bit positions of the output block
//  - out_reg_e and decode_out_sel(): output-block register decode helper
package io_map_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Input-port block map (read-only partner block)
    localparam logic [5:0] SEL_IN_PORT0  = 6'b010000;
    localparam logic [5:0] SEL_IN_PORT1  = 6'b010001;
    localparam logic [5:0] SEL_IN_STATUS = 6'b010010;

    // Output-port block map
    localparam logic [5:0] SEL_OUT_BASE   = 6'b100000;
    localparam logic [5:0] OFF_OUT_PORT0  = 6'd0;
    localparam logic [5:0] OFF_OUT_PORT1  = 6'd1;
    localparam logic [5:0] OFF_OUT_PORT2  = 6'd2;
    localparam logic [5:0] OFF_OUT_CTRL   = 6'd3;
    localparam logic [5:0] OFF_OUT_STATUS = 6'd4;

    // CTRL register bits
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;

    // STATUS register fields
    localparam int STATUS_DIRTY_LSB = 0;
    localparam int STATUS_DIRTY_W   = 3;
    localparam int STATUS_CNT_LSB   = 8;

    typedef enum logic [2:0] {
        REG_PORT0,
        REG_PORT1,
        REG_PORT2,
        REG_CTRL,
        REG_STATUS,
        REG_NONE
    } out_reg_e;

    // Offset from the block base; the subtraction wraps in 6 bits, so any
    // select below the base lands far above OFF_OUT_STATUS and decodes as none.
    function automatic out_reg_e decode_out_sel(input logic [5:0] sel,
                                                input logic [5:0] base);
        logic [5:0] off;
        off = sel - base;
        case (off)
            OFF_OUT_PORT0:  return REG_PORT0;
            OFF_OUT_PORT1:  return REG_PORT1;
            OFF_OUT_PORT2:  return REG_PORT2;
            OFF_OUT_CTRL:   return REG_CTRL;
            OFF_OUT_STATUS: return REG_STATUS;
            default:        return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_output_mux.sv
// io_output_mux: combinational readback select for the output-port block.
//  sel         in  6       addr[7:2] of the current access
//  stage0..2   in  WIDTH   staging registers
//  auto_mode   in  1       auto-commit flag (CTRL bit 1)
//  commit_cnt  in  CNT_W   commit counter
//  dirty       in  3       per-port staged-but-uncommitted flags
//  read_data   out WIDTH   selected register, 0 for unmapped selects
module io_output_mux
    import io_map_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEFAULT,
    parameter int         CNT_W    = 8,
    parameter logic [5:0] SEL_BASE = SEL_OUT_BASE
) (
    input  logic [5:0]       sel,
    input  logic [WIDTH-1:0] stage0,
    input  logic [WIDTH-1:0] stage1,
    input  logic [WIDTH-1:0] stage2,
    input  logic             auto_mode,
    input  logic [CNT_W-1:0] commit_cnt,
    input  logic [2:0]       dirty,
    output logic [WIDTH-1:0] read_data
);

    always_comb begin
        read_data = '0;
        case (decode_out_sel(sel, SEL_BASE))
            REG_PORT0: read_data = stage0;
            REG_PORT1: read_data = stage1;
            REG_PORT2: read_data = stage2;
            REG_CTRL:  read_data[CTRL_AUTO] = auto_mode;
            REG_STATUS: begin
                read_data[STATUS_CNT_LSB +: CNT_W]            = commit_cnt;
                read_data[STATUS_DIRTY_LSB +: STATUS_DIRTY_W] = dirty;
            end
            default:   read_data = '0;
        endcase
    end

endmodule

// File: rtl/io_output_reg.sv
// io_output_reg: memory-mapped output ports with staged, atomic commit.
// CPU stores go to per-port staging registers; a CTRL commit copies all of
// them to the physical ports on one edge. In auto mode a port store drives
// its output directly.
//  io_clk         in  1      IO clock, all state on posedge
//  reset          in  1      synchronous active-high reset
//  addr           in  32     CPU byte address, addr[7:2] decoded
//  io_wen         in  1      store strobe
//  io_byte_en     in  4      byte lanes for port stores
//  io_write_data  in  WIDTH  store data
//  io_read_data   out WIDTH  combinational readback of addr
//  out_port0..2   out WIDTH  committed output ports
//  update_pulse   out 1      one cycle high after each commit edge
// Byte lanes assume WIDTH >= 32.
module io_output_reg
    import io_map_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEFAULT,
    parameter logic [5:0] SEL_BASE = SEL_OUT_BASE,
    parameter int         CNT_W    = 8
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             io_wen,
    input  logic [3:0]       io_byte_en,
    input  logic [WIDTH-1:0] io_write_data,
    output logic [WIDTH-1:0] io_read_data,
    output logic [WIDTH-1:0] out_port0,
    output logic [WIDTH-1:0] out_port1,
    output logic [WIDTH-1:0] out_port2,
    output logic             update_pulse
);

    logic [WIDTH-1:0] stage   [0:2];
    logic [WIDTH-1:0] out_reg [0:2];
    logic [2:0]       dirty;
    logic             auto_mode;
    logic [CNT_W-1:0] commit_cnt;

    logic [5:0]       sel;
    out_reg_e         region;
    logic             port_store;
    logic             ctrl_store;
    logic             commit_go;
    logic [1:0]       port_idx;
    logic [WIDTH-1:0] merged;
    logic             unused_addr;

    assign sel         = addr[7:2];
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_val,
                                                     input logic [WIDTH-1:0] new_val,
                                                     input logic [3:0]       be);
        logic [WIDTH-1:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    // A store with no byte lanes enabled is treated as if it never happened.
    always_comb begin
        region     = decode_out_sel(sel, SEL_BASE);
        port_store = 1'b0;
        ctrl_store = 1'b0;
        port_idx   = 2'd0;
        case (region)
            REG_PORT0: begin port_idx = 2'd0; port_store = io_wen && (io_byte_en != 4'd0); end
            REG_PORT1: begin port_idx = 2'd1; port_store = io_wen && (io_byte_en != 4'd0); end
            REG_PORT2: begin port_idx = 2'd2; port_store = io_wen && (io_byte_en != 4'd0); end
            REG_CTRL:  ctrl_store = io_wen;
            default:   ;
        endcase
        commit_go = ctrl_store && io_write_data[CTRL_COMMIT] && (dirty != 3'd0);
        merged    = merge_bytes(stage[port_idx], io_write_data, io_byte_en);
    end

    // Port stores and CTRL stores are mutually exclusive (one address per
    // edge), so the two branches never fight over out_reg or the counter.
    // An auto-mode store leaves out_port equal to stage, so its dirty flag is
    // cleared. A commit copies the stage values from before this edge.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                stage[i]   <= '0;
                out_reg[i] <= '0;
            end
            dirty        <= '0;
            auto_mode    <= 1'b0;
            commit_cnt   <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (port_store) begin
                stage[port_idx] <= merged;
                if (auto_mode) begin
                    out_reg[port_idx] <= merged;
                    dirty[port_idx]   <= 1'b0;
                    update_pulse      <= 1'b1;
                    commit_cnt        <= commit_cnt + CNT_W'(1);
                end else begin
                    dirty[port_idx]   <= 1'b1;
                end
            end
            if (ctrl_store) begin
                auto_mode <= io_write_data[CTRL_AUTO];
                if (commit_go) begin
                    for (int i = 0; i < 3; i++) begin
                        out_reg[i] <= stage[i];
                    end
                    dirty        <= '0;
                    update_pulse <= 1'b1;
                    commit_cnt   <= commit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_port0 = out_reg[0];
    assign out_port1 = out_reg[1];
    assign out_port2 = out_reg[2];

    io_output_mux #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .SEL_BASE (SEL_BASE)
    ) u_mux (
        .sel        (sel),
        .stage0     (stage[0]),
        .stage1     (stage[1]),
        .stage2     (stage[2]),
        .auto_mode  (auto_mode),
        .commit_cnt (commit_cnt),
        .dirty      (dirty),
        .read_data  (io_read_data)
    );

endmodule
